memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/common_types_pkg.sv | 66 ++++++
 rtl/memory_stage_load_extend.sv | 28 ++
 rtl/memory_stage.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/common_types_pkg.sv
// rtl/common_types_pkg.sv - shared types and access helpers for the memory stage
package common_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_t;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_BYTE = 2'd1,
    ST_HALF = 2'd2,
    ST_WORD = 2'd3
  } store_size_e;

  typedef enum logic [1:0] {
    LD_BYTE = 2'd0,
    LD_HALF = 2'd1,
    LD_WORD = 2'd2
  } load_size_e;

  typedef enum logic [1:0] {
    SRC_ALU     = 2'd0,
    SRC_LOAD    = 2'd1,
    SRC_PC4     = 2'd2,
    SRC_ALU_ALT = 2'd3
  } wr_src_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } mem_state_e;

  // Access width as log2(bytes): 0 byte, 1 halfword, 2 word. Load size 3 is taken as word.
  function automatic logic [1:0] access_log2(input logic is_store, input store_size_e st,
                                             input load_size_e ld);
    if (is_store)
      access_log2 = (st == ST_BYTE) ? 2'd0 : (st == ST_HALF) ? 2'd1 : 2'd2;
    else
      access_log2 = (ld == LD_BYTE) ? 2'd0 : (ld == LD_HALF) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic access_misaligned(input logic [1:0] lg, input logic [1:0] lo);
    case (lg)
      2'd0:    access_misaligned = 1'b0;
      2'd1:    access_misaligned = lo[0];
      default: access_misaligned = (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] access_strobe(input logic [1:0] lg, input logic [1:0] lo);
    case (lg)
      2'd0:    access_strobe = 4'b0001 << lo;
      2'd1:    access_strobe = 4'b0011 << lo;
      default: access_strobe = 4'b1111;
    endcase
  endfunction

  // Copy the low byte/halfword into every lane so whichever lanes are strobed carry it.
  function automatic word_t lane_replicate(input logic [1:0] lg, input word_t d);
    case (lg)
      2'd0:    lane_replicate = {4{d[7:0]}};
      2'd1:    lane_replicate = {2{d[15:0]}};
      default: lane_replicate = d;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_load_extend.sv
// rtl/memory_stage_load_extend.sv - load lane select and zero/sign extension
module load_extend
  import common_types_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  load_size_e  size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
  assign lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Pick the addressed lane and widen it to a full word; words pass through untouched.
  always_comb begin
    data = rdata;
    case (size)
      LD_BYTE: data = {{24{sign_ext & lane_b[7]}}, lane_b};
      LD_HALF: data = {{16{sign_ext & lane_h[15]}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - memory pipeline stage: data-bus access and writeback latch
module memory_stage
  import common_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exm_valid,
  input  logic        exm_flush,
  input  logic [31:0] exm_pc,
  input  logic        exm_halt,
  input  logic [4:0]  exm_rd,
  input  logic        exm_dread,
  input  logic [1:0]  exm_dwrite,
  input  logic [1:0]  exm_reg_wr_src,
  input  logic [1:0]  exm_reg_wr_mem,
  input  logic        exm_reg_wr_mem_signed,
  input  logic [31:0] exm_alu_out,
  input  logic [31:0] exm_rdat2,
  output logic        dmem_ren,
  output logic        dmem_wen,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_strobe,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_halt,
  output logic        wb_misaligned
);

  mem_state_e  state_q, state_d;
  store_size_e st_size;
  load_size_e  ld_size;
  wr_src_e     wr_src;
  logic        is_store, is_load, mem_op, misaligned, live;
  logic [1:0]  acc_lg;
  logic        access_go, complete, flushed_q;
  word_t       load_data, wb_data_d;

  assign st_size    = store_size_e'(exm_dwrite);
  assign ld_size    = load_size_e'(exm_reg_wr_mem);
  assign wr_src     = wr_src_e'(exm_reg_wr_src);
  // A store wins when both load and store are flagged.
  assign is_store   = (st_size != ST_NONE);
  assign is_load    = exm_dread && !is_store;
  assign mem_op     = is_store || is_load;
  assign acc_lg     = access_log2(is_store, st_size, ld_size);
  assign misaligned = mem_op && access_misaligned(acc_lg, exm_alu_out[1:0]);
  assign live       = exm_valid && !exm_flush;

  load_extend u_load_extend (
    .rdata    (dmem_rdata),
    .addr_lo  (exm_alu_out[1:0]),
    .size     (ld_size),
    .sign_ext (exm_reg_wr_mem_signed),
    .data     (load_data)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Enter BUS on a live aligned access; leave when the bus reports ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (access_go) state_d = S_BUS;
      S_BUS:   if (dmem_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: request launch, completion and the upstream stall.
  always_comb begin
    access_go = 1'b0;
    complete  = 1'b0;
    mem_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        access_go = live && mem_op && !misaligned;
        mem_stall = access_go;
      end
      S_BUS: begin
        complete  = dmem_ready;
        mem_stall = !dmem_ready;
      end
      default: ;
    endcase
  end

  // Registered bus request; address/data/strobe stay put after completion, only the enables drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_ren    <= 1'b0;
      dmem_wen    <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      dmem_strobe <= '0;
    end else if (access_go) begin
      dmem_ren    <= is_load;
      dmem_wen    <= is_store;
      dmem_addr   <= {exm_alu_out[31:2], 2'b00};
      dmem_wdata  <= lane_replicate(acc_lg, exm_rdat2);
      dmem_strobe <= access_strobe(acc_lg, exm_alu_out[1:0]);
    end else if (complete) begin
      dmem_ren    <= 1'b0;
      dmem_wen    <= 1'b0;
    end
  end

  // Remember a flush seen mid-transaction so the completion turns into a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               flushed_q <= 1'b0;
    else if (complete)                     flushed_q <= 1'b0;
    else if (state_q == S_BUS && exm_flush) flushed_q <= 1'b1;
  end

  // Writeback value select; source 3 falls back to the ALU result.
  always_comb begin
    wb_data_d = exm_alu_out;
    case (wr_src)
      SRC_LOAD: wb_data_d = load_data;
      SRC_PC4:  wb_data_d = exm_pc + 32'd4;
      default:  wb_data_d = exm_alu_out;
    endcase
  end

  // Writeback latch: bubble while stalled or killed, otherwise capture the instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      wb_halt       <= 1'b0;
      wb_misaligned <= 1'b0;
    end else if (mem_stall || !live || flushed_q) begin
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      wb_halt       <= 1'b0;
      wb_misaligned <= 1'b0;
    end else begin
      wb_valid      <= 1'b1;
      wb_rd         <= misaligned ? 5'd0 : exm_rd;
      wb_data       <= wb_data_d;
      wb_halt       <= exm_halt;
      wb_misaligned <= misaligned;
    end
  end

endmodule
